onn_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the oscillatory neural network array. It serially loads initial neuron phases and enables the neuron bank. It issues per-period drop/check strobes and monitors per-neuron state-change flags to declare convergence (steady) or timeout (inconsistent). It generalises the fixed 3x5 loader-plus-FSM pair to any neuron count and phase width, and adds run/steady/timeout status.

---
 rtl/onn_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_onn_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onn_seq_ctrl.sv
// onn_seq_ctrl: serial phase loader and run sequencer for the ONN array.
// Loads SW = N_NEURON*PHASE_W phase bits MSB-first, then runs the neuron
// bank, issuing drop/state_check strobes each PERIOD and declaring steady
// (STEADY_PERIODS change-free checks) or inconsistent (MAX_PERIODS checks).
// Ports: sclk, re (async active-high reset), data_in/load (serial load),
//   start (run pulse), state_changed (per-neuron flags) -> state, load_done,
//   re_n, drop, state_check, busy, steady, inconsistent, period_cnt,
//   n_changed.
// Option: define ONN_POPCOUNT_EN to register the popcount of state_changed
//   on n_changed; otherwise n_changed is tied to zero.
module onn_seq_ctrl #(
  parameter int N_NEURON       = 15,
  parameter int PHASE_W        = 4,
  parameter int PERIOD         = 16,
  parameter int STEADY_PERIODS = 3,
  parameter int MAX_PERIODS    = 255,
  localparam int SW  = N_NEURON * PHASE_W,
  localparam int PCW = $clog2(MAX_PERIODS + 1),
  localparam int NCW = $clog2(N_NEURON + 1)
) (
  input  logic                sclk,
  input  logic                re,
  input  logic                data_in,
  input  logic                load,
  input  logic                start,
  input  logic [N_NEURON-1:0] state_changed,
  output logic [SW-1:0]       state,
  output logic                load_done,
  output logic                re_n,
  output logic                drop,
  output logic                state_check,
  output logic                busy,
  output logic                steady,
  output logic                inconsistent,
  output logic [PCW-1:0]      period_cnt,
  output logic [NCW-1:0]      n_changed
);

  localparam int SCW = $clog2(STEADY_PERIODS + 1);
  localparam int PHW = $clog2(PERIOD);
  localparam int BCW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_READY,
    S_RUN,
    S_STEADY,
    S_TIMEOUT
  } fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [SW-1:0]  sr_q, sr_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           load_done_q, load_done_d;
  logic           re_n_q, re_n_d;
  logic           drop_q, drop_d;
  logic           check_q, check_d;
  logic           busy_q, busy_d;
  logic           steady_q, steady_d;
  logic           incons_q, incons_d;
  logic [PCW-1:0] period_q, period_d;
  logic [SCW-1:0] stable_q, stable_d;
  logic [PHW-1:0] phase_q, phase_d;

  logic [SW-1:0]  shift_in;
  logic [BCW-1:0] bit_inc;
  logic [PCW-1:0] period_inc;
  logic [SCW-1:0] stable_nx;
  logic           reload;
  logic           launch;
  logic           run_stay;

  assign shift_in = {sr_q[SW-2:0], data_in};
  assign bit_inc  = bit_cnt_q + 1'b1;

  // Saturating check counter and change-free streak.
  assign period_inc = (period_q == PCW'(MAX_PERIODS)) ?
                      period_q : period_q + 1'b1;
  assign stable_nx  = (state_changed != '0) ? '0 :
                      (stable_q == SCW'(STEADY_PERIODS)) ?
                      stable_q : stable_q + 1'b1;

  always_comb begin
    fsm_d       = fsm_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    load_done_d = load_done_q;
    steady_d    = steady_q;
    incons_d    = incons_q;
    period_d    = period_q;
    stable_d    = stable_q;
    phase_d     = phase_q;
    reload      = 1'b0;
    launch      = 1'b0;

    unique case (fsm_q)
      S_IDLE: reload = load;
      S_SHIFT: begin
        if (load) begin
          sr_d = shift_in;
          if (bit_inc == BCW'(SW)) begin
            fsm_d       = S_READY;
            bit_cnt_d   = '0;
            load_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_inc;
          end
        end else begin
          fsm_d     = S_IDLE;
          bit_cnt_d = '0;
        end
      end
      S_READY, S_STEADY, S_TIMEOUT: begin
        reload = load;
        launch = start & ~load;
      end
      S_RUN: begin
        phase_d = (phase_q == PHW'(PERIOD - 1)) ?
                  '0 : phase_q + 1'b1;
        if (check_q) begin
          period_d = period_inc;
          stable_d = stable_nx;
          // A tie between convergence and timeout resolves to steady.
          if (stable_nx == SCW'(STEADY_PERIODS)) begin
            fsm_d    = S_STEADY;
            steady_d = 1'b1;
          end else if (period_inc == PCW'(MAX_PERIODS)) begin
            fsm_d    = S_TIMEOUT;
            incons_d = 1'b1;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    if (reload) begin
      fsm_d       = S_SHIFT;
      sr_d        = shift_in;
      bit_cnt_d   = BCW'(1);
      load_done_d = 1'b0;
      steady_d    = 1'b0;
      incons_d    = 1'b0;
    end

    if (launch) begin
      fsm_d    = S_RUN;
      phase_d  = '0;
      stable_d = '0;
      period_d = '0;
      steady_d = 1'b0;
      incons_d = 1'b0;
    end

    // Strobes only while staying in RUN, so stale phase never leaks
    // into the first cycle of a new run or into a terminal state.
    run_stay = (fsm_q == S_RUN) && (fsm_d == S_RUN);
    re_n_d   = (fsm_d == S_RUN);
    drop_d   = run_stay && (phase_q == PHW'(PERIOD - 1));
    check_d  = run_stay && drop_q;
    busy_d   = (fsm_d == S_SHIFT) || (fsm_d == S_RUN);
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      fsm_q       <= S_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      load_done_q <= 1'b0;
      re_n_q      <= 1'b0;
      drop_q      <= 1'b0;
      check_q     <= 1'b0;
      busy_q      <= 1'b0;
      steady_q    <= 1'b0;
      incons_q    <= 1'b0;
      period_q    <= '0;
      stable_q    <= '0;
      phase_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      load_done_q <= load_done_d;
      re_n_q      <= re_n_d;
      drop_q      <= drop_d;
      check_q     <= check_d;
      busy_q      <= busy_d;
      steady_q    <= steady_d;
      incons_q    <= incons_d;
      period_q    <= period_d;
      stable_q    <= stable_d;
      phase_q     <= phase_d;
    end
  end

`ifdef ONN_POPCOUNT_EN
  logic [NCW-1:0] pop;
  logic [NCW-1:0] nchg_q, nchg_d;
  logic           nchg_clr;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      pop = pop + NCW'(state_changed[i]);
    end
  end

  // Cleared by any accepted load or start; load is ignored only in RUN.
  assign nchg_clr = (load && fsm_q != S_RUN) ||
                    (start && (fsm_q == S_READY ||
                               fsm_q == S_STEADY ||
                               fsm_q == S_TIMEOUT));

  always_comb begin
    nchg_d = nchg_q;
    if (nchg_clr) begin
      nchg_d = '0;
    end else if (fsm_q == S_RUN && check_q) begin
      nchg_d = pop;
    end
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      nchg_q <= '0;
    end else begin
      nchg_q <= nchg_d;
    end
  end

  assign n_changed = nchg_q;
`else
  assign n_changed = '0;
`endif

  assign state        = sr_q;
  assign load_done    = load_done_q;
  assign re_n         = re_n_q;
  assign drop         = drop_q;
  assign state_check  = check_q;
  assign busy         = busy_q;
  assign steady       = steady_q;
  assign inconsistent = incons_q;
  assign period_cnt   = period_q;

endmodule

// File: tb/tb_onn_seq_ctrl.sv
// tb_onn_seq_ctrl: randomized bench with a behavioural reference model.
// Three instances differ only in MAX_PERIODS (255, 8, 3).
module tb_onn_seq_ctrl;

  localparam int NN  = 15;
  localparam int PW  = 4;
  localparam int SW  = NN * PW;
  localparam int PER = 16;
  localparam int SP  = 3;
  localparam int NI  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SHIFT = 1;
  localparam int M_READY = 2;
  localparam int M_RUN   = 3;
  localparam int M_STDY  = 4;
  localparam int M_TOUT  = 5;

  localparam logic [SW-1:0] KPAT = 60'hFEDCBA987654321;

  logic          sclk = 1'b0;
  logic          re;
  logic          data_in = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic [NN-1:0] sc = '0;

  logic [SW-1:0] o_state [NI];
  logic          o_done  [NI];
  logic          o_ren   [NI];
  logic          o_drop  [NI];
  logic          o_chk   [NI];
  logic          o_busy  [NI];
  logic          o_st    [NI];
  logic          o_inc   [NI];
  logic [7:0]    o_pc    [NI];
  logic [3:0]    o_nc    [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 sclk = ~sclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MP = (g == 0) ? 255 : ((g == 1) ? 8 : 3);
    logic [$clog2(MP+1)-1:0] pc;
    onn_seq_ctrl #(
      .N_NEURON(NN), .PHASE_W(PW), .PERIOD(PER),
      .STEADY_PERIODS(SP), .MAX_PERIODS(MP)
    ) u_dut (
      .sclk(sclk), .re(re), .data_in(data_in), .load(load),
      .start(start), .state_changed(sc),
      .state(o_state[g]), .load_done(o_done[g]), .re_n(o_ren[g]),
      .drop(o_drop[g]), .state_check(o_chk[g]), .busy(o_busy[g]),
      .steady(o_st[g]), .inconsistent(o_inc[g]),
      .period_cnt(pc), .n_changed(o_nc[g])
    );
    assign o_pc[g] = 8'(pc);
  end

  // ---------------- reference model ----------------
  int          m_mode   [NI];
  int          m_bits   [NI];
  bit [SW-1:0] m_sr     [NI];
  bit          m_done   [NI];
  int          m_t      [NI];
  int          m_chk    [NI];
  int          m_streak [NI];
  int          m_nc     [NI];

  function automatic int maxp(input int k);
    return (k == 0) ? 255 : ((k == 1) ? 8 : 3);
  endfunction

  function automatic void m_reset(input int k);
    m_mode[k] = M_IDLE; m_bits[k] = 0; m_sr[k] = '0;
    m_done[k] = 0; m_t[k] = 0; m_chk[k] = 0;
    m_streak[k] = 0; m_nc[k] = 0;
  endfunction

  function automatic void m_newload(input int k);
    m_sr[k]   = {m_sr[k][SW-2:0], data_in};
    m_bits[k] = 1;
    m_done[k] = 0;
    m_nc[k]   = 0;
    m_mode[k] = M_SHIFT;
  endfunction

  function automatic void m_step(input int k);
    bit chk_now;
    chk_now = (m_mode[k] == M_RUN) && (m_t[k] > 1) &&
              ((m_t[k] - 1) % PER == 0);
    case (m_mode[k])
      M_IDLE: if (load) m_newload(k);
      M_SHIFT: begin
        if (load) begin
          m_sr[k] = {m_sr[k][SW-2:0], data_in};
          m_bits[k]++;
          m_nc[k] = 0;
          if (m_bits[k] == SW) begin
            m_mode[k] = M_READY;
            m_done[k] = 1;
          end
        end else begin
          m_mode[k] = M_IDLE;
          m_bits[k] = 0;
        end
      end
      M_READY, M_STDY, M_TOUT: begin
        if (load) m_newload(k);
        else if (start) begin
          m_mode[k] = M_RUN; m_t[k] = 0; m_chk[k] = 0;
          m_streak[k] = 0; m_nc[k] = 0;
        end
      end
      M_RUN: begin
        if (chk_now) begin
          if (m_chk[k] < maxp(k)) m_chk[k]++;
          m_streak[k] = (sc == '0) ? m_streak[k] + 1 : 0;
          m_nc[k] = $countones(sc);
          if (m_streak[k] >= SP) m_mode[k] = M_STDY;
          else if (m_chk[k] == maxp(k)) m_mode[k] = M_TOUT;
        end
        m_t[k]++;
      end
      default: m_reset(k);
    endcase
  endfunction

  always @(posedge sclk or posedge re) begin
    for (int k = 0; k < NI; k++) begin
      if (re) m_reset(k);
      else m_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h",
               nm, k, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    bit run;
    int nc_exp;
    run = (m_mode[k] == M_RUN);
`ifdef ONN_POPCOUNT_EN
    nc_exp = m_nc[k];
`else
    nc_exp = 0;
`endif
    cmp("state", k, 64'(o_state[k]), 64'(m_sr[k]));
    cmp("load_done", k, 64'(o_done[k]), 64'(m_done[k]));
    cmp("re_n", k, 64'(o_ren[k]), 64'(run));
    cmp("drop", k, 64'(o_drop[k]),
        64'(run && m_t[k] > 0 && m_t[k] % PER == 0));
    cmp("state_check", k, 64'(o_chk[k]),
        64'(run && m_t[k] > 1 && (m_t[k] - 1) % PER == 0));
    cmp("busy", k, 64'(o_busy[k]),
        64'(run || m_mode[k] == M_SHIFT));
    cmp("steady", k, 64'(o_st[k]), 64'(m_mode[k] == M_STDY));
    cmp("inconsistent", k, 64'(o_inc[k]), 64'(m_mode[k] == M_TOUT));
    cmp("period_cnt", k, 64'(o_pc[k]), 64'(m_chk[k]));
    cmp("n_changed", k, 64'(o_nc[k]), 64'(nc_exp));
  endtask

  always @(negedge sclk) begin
    for (int k = 0; k < NI; k++) check_inst(k);
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic load_word(input logic [SW-1:0] w, input int nbits);
    logic [SW-1:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) begin
      data_in = v[SW-1-i];
      load = 1'b1;
      tick();
    end
    load = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int drops[$];
    int cyc;
    logic [SW-1:0] w;

    re = 1'b1;
    repeat (3) tick();
    cmp("rst_state", 0, 64'(o_state[0]), 64'd0);
    cmp("rst_busy", 0, 64'(o_busy[0]), 64'd0);
    re = 1'b0;
    tick();

    // Full load of the reference pattern.
    load_word(KPAT, SW);
    cmp("load_state", 0, 64'(o_state[0]), 64'(KPAT));
    cmp("load_done", 0, 64'(o_done[0]), 64'd1);
    cmp("load_busy", 0, 64'(o_busy[0]), 64'd0);
    cmp("mdl_sr", 0, 64'(m_sr[0]), 64'(KPAT));

    // Early abort after 20 bits, then full reload.
    w = {$urandom, $urandom};
    load_word(w, 20);
    tick();
    cmp("abort_done", 0, 64'(o_done[0]), 64'd0);
    cmp("abort_busy", 0, 64'(o_busy[0]), 64'd0);
    load_word(KPAT, SW);
    cmp("reload_state", 0, 64'(o_state[0]), 64'(KPAT));
    cmp("reload_done", 0, 64'(o_done[0]), 64'd1);

    // Convergence: changes on first two checks, then quiet.
    pulse_start();
    cmp("run_ren", 0, 64'(o_ren[0]), 64'd1);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      sc = (m_chk[0] < 2) ? NN'(1) : '0;
      tick();
      cyc++;
      if (o_drop[0]) drops.push_back(cyc);
      if (o_st[0]) break;
    end
    sc = '0;
    cmp("conv_steady", 0, 64'(o_st[0]), 64'd1);
    cmp("conv_pcnt", 0, 64'(o_pc[0]), 64'd5);
    cmp("conv_ren", 0, 64'(o_ren[0]), 64'd0);
    cmp("conv_incons", 0, 64'(o_inc[0]), 64'd0);
    cmp("conv_ndrops", 0, 64'(drops.size()), 64'd5);
    if (drops.size() > 0) cmp("first_drop", 0, 64'(drops[0]), 64'd16);
    for (int i = 1; i < drops.size(); i++)
      cmp("drop_gap", 0, 64'(drops[i] - drops[i-1]), 64'd16);
    cmp("inst2_tout", 2, 64'(o_inc[2]), 64'd1);

    // Timeout with MAX_PERIODS=8, alternating change patterns.
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      sc = (m_chk[1] % 2 == 0) ? NN'(15'h7FFF) : '0;
      tick();
      if (o_inc[1]) break;
    end
    sc = '0;
    cmp("tout_incons", 1, 64'(o_inc[1]), 64'd1);
    cmp("tout_pcnt", 1, 64'(o_pc[1]), 64'd8);
    cmp("tout_steady", 1, 64'(o_st[1]), 64'd0);

    // Tie with MAX_PERIODS=3: steady wins.
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (o_st[2] || o_inc[2]) break;
    end
    cmp("tie_steady", 2, 64'(o_st[2]), 64'd1);
    cmp("tie_incons", 2, 64'(o_inc[2]), 64'd0);
    cmp("tie_pcnt", 2, 64'(o_pc[2]), 64'd3);

    // Reset in period 2 at phase 7.
    pulse_start();
    sc = NN'(15'h00FF);
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 20) begin
`ifdef ONN_POPCOUNT_EN
        cmp("pop_nchg", 2, 64'(o_nc[2]), 64'd8);
`else
        cmp("pop_nchg", 2, 64'(o_nc[2]), 64'd0);
`endif
      end
    end
    cmp("prerst_ren", 2, 64'(o_ren[2]), 64'd1);
    re = 1'b1;
    #1;
    cmp("arst_state", 2, 64'(o_state[2]), 64'd0);
    cmp("arst_ren", 2, 64'(o_ren[2]), 64'd0);
    cmp("arst_busy", 2, 64'(o_busy[2]), 64'd0);
    cmp("arst_pcnt", 2, 64'(o_pc[2]), 64'd0);
    cmp("arst_done", 2, 64'(o_done[2]), 64'd0);
    tick();
    re = 1'b0;
    sc = '0;
    tick();

    // Randomized traffic.
    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 5))
        0: load_word({$urandom, $urandom}, SW);
        1: begin
          load_word({$urandom, $urandom}, $urandom_range(1, SW - 1));
          tick();
        end
        2: begin
          pulse_start();
          repeat ($urandom_range(20, 300)) begin
            sc = ($urandom_range(0, 2) == 0) ? NN'($urandom) : '0;
            tick();
          end
          sc = '0;
        end
        3: begin
          load = 1'b1; start = 1'b1; data_in = 1'($urandom);
          tick();
          start = 1'b0;
          repeat ($urandom_range(1, 8)) begin
            load = 1'($urandom); data_in = 1'($urandom);
            tick();
          end
          load = 1'b0;
        end
        4: begin
          re = 1'b1;
          tick();
          re = 1'b0;
          tick();
        end
        default: begin
          repeat (30) begin
            load    = ($urandom_range(0, 3) != 0);
            start   = ($urandom_range(0, 7) == 0);
            data_in = 1'($urandom);
            sc      = NN'($urandom);
            tick();
          end
          load = 1'b0; start = 1'b0; sc = '0;
        end
      endcase
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
